// File: rtl/dec_owner_arb.sv
// Decode-stage ownership arbiter: fixed-priority grant among sub-decoders, with
// optional multi-cycle locking by the winner, a hold watchdog, stall freeze and flush abort.
module dec_owner_arb #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 15,
  localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               stall,
  input  logic               flush,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               hold_err,
  output logic               conflict
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]         state_q,    state_d;
  logic [SEL_W-1:0]   owner_q,    owner_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               busy_q,     busy_d;
  logic               hold_err_q, hold_err_d;
  logic               conflict_q, conflict_d;

  logic [NUM_REQ-1:0] lower_any;
  logic [NUM_REQ-1:0] first_req;
  logic [NUM_REQ-1:0] owner_oh;
  logic               multi_req;

  // lower_any[i] is set when some request below index i is active.
  assign lower_any[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REQ; gi++) begin : g_chain
      assign lower_any[gi] = lower_any[gi-1] | req[gi-1];
    end
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
      assign first_req[gi] = req[gi] & ~lower_any[gi];
      assign owner_oh[gi]  = (owner_q == SEL_W'(gi));
    end
  endgenerate

  assign multi_req = |(req & lower_any);

  always_comb begin
    gnt = '0;
    if (reset && !flush) begin
      gnt = (state_q == ST_OWNED) ? owner_oh : first_req;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel = SEL_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    hold_err_d = 1'b0;
    conflict_d = 1'b0;
    if (flush) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
    end else if (!stall) begin
      if (state_q == ST_IDLE) begin
        conflict_d = multi_req;
        if (|gnt && lock[sel]) begin
          state_d    = ST_OWNED;
          owner_d    = sel;
          hold_cnt_d = '0;
        end
      end else begin
        if (!lock[owner_q]) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt_q >= CNT_W'(MAX_HOLD)) begin
          // Watchdog: the owner has used its full hold budget.
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          hold_err_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
    end
    busy_d = (state_d == ST_OWNED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      hold_err_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      hold_err_q <= hold_err_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy     = busy_q;
  assign hold_err = hold_err_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_dec_owner_arb.sv
// Directed bench for dec_owner_arb (NUM_REQ=4, MAX_HOLD=15): grants, locking,
// watchdog, stall, flush and reset behaviour with hand-computed expectations.
module tb_dec_owner_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] lock;
  logic       stall;
  logic       flush;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       hold_err;
  logic       conflict;

  int checks = 0;
  int errors = 0;

  dec_owner_arb #(.NUM_REQ(4), .MAX_HOLD(15)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .stall(stall), .flush(flush),
    .gnt(gnt), .sel(sel), .busy(busy), .hold_err(hold_err), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = 4'b1111; lock = 4'b1111; stall = 1'b0; flush = 1'b0;

    // Reset: grant forced low whatever the inputs.
    nxt(); #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", sel, 2'd0);
    nxt(); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hold_err", hold_err, 1'b0);
    chk("rst_conflict", conflict, 1'b0);

    // Two requesters, no lock: lowest wins for one cycle, conflict follows.
    reset = 1'b1; req = 4'b0110; lock = 4'b0000; #1;
    chk("c1_gnt", gnt, 4'b0010);
    chk("c1_sel", sel, 2'd1);
    nxt(); req = 4'b0000; #1;
    chk("c1_conflict", conflict, 1'b1);
    chk("c1_busy", busy, 1'b0);
    chk("c1_idle_gnt", gnt, 4'b0000);
    nxt(); #1;
    chk("c1_conflict_clr", conflict, 1'b0);

    // Owner 3 locks for three cycles, releases on the fourth; req[0] ignored meanwhile.
    req = 4'b1000; lock = 4'b1000; #1;
    chk("c2_gnt0", gnt, 4'b1000);
    chk("c2_sel0", sel, 2'd3);
    chk("c2_busy0", busy, 1'b0);
    nxt(); req = 4'b1001; #1;
    chk("c2_gnt1", gnt, 4'b1000);
    chk("c2_busy1", busy, 1'b1);
    nxt(); #1;
    chk("c2_gnt2", gnt, 4'b1000);
    chk("c2_busy2", busy, 1'b1);
    nxt(); lock = 4'b0000; #1;
    chk("c2_gnt3", gnt, 4'b1000);
    chk("c2_busy3", busy, 1'b1);
    nxt(); #1;
    chk("c2_busy_end", busy, 1'b0);
    chk("c2_conflict", conflict, 1'b0);
    chk("c2_idle_gnt", gnt, 4'b0001);
    req = 4'b0000; #1;
    nxt();

    // Stall in IDLE: grant still visible, but no lock entry and no conflict.
    req = 4'b0011; lock = 4'b0001; stall = 1'b1; #1;
    chk("c3_gnt", gnt, 4'b0001);
    nxt(); req = 4'b0000; lock = 4'b0000; stall = 1'b0; #1;
    chk("c3_conflict", conflict, 1'b0);
    chk("c3_busy", busy, 1'b0);

    // Owner 2 holds forever: entry + 16 OWNED cycles, then watchdog pulse.
    req = 4'b0100; lock = 4'b0100; #1;
    chk("c4_gnt_entry", gnt, 4'b0100);
    for (int i = 1; i <= 16; i++) begin
      nxt(); #1;
      chk($sformatf("c4_gnt_%0d", i), gnt, 4'b0100);
      chk($sformatf("c4_busy_%0d", i), busy, 1'b1);
      chk($sformatf("c4_herr_%0d", i), hold_err, 1'b0);
    end
    nxt(); req = 4'b0000; lock = 4'b0000; #1;
    chk("c4_hold_err", hold_err, 1'b1);
    chk("c4_busy_end", busy, 1'b0);
    chk("c4_gnt_end", gnt, 4'b0000);
    nxt(); #1;
    chk("c4_hold_err_clr", hold_err, 1'b0);

    // Owner 1 locked, stalled 5 cycles: the hold budget must not move during the stall.
    req = 4'b0010; lock = 4'b0010; #1;
    chk("c5_gnt_entry", gnt, 4'b0010);
    nxt(); #1;
    chk("c5_busy", busy, 1'b1);
    nxt(); stall = 1'b1; req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("c5_stall_gnt_%0d", i), gnt, 4'b0010);
      nxt();
      chk($sformatf("c5_stall_busy_%0d", i), busy, 1'b1);
      chk($sformatf("c5_stall_herr_%0d", i), hold_err, 1'b0);
    end
    stall = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("c5_run_gnt_%0d", i), gnt, 4'b0010);
      chk($sformatf("c5_run_busy_%0d", i), busy, 1'b1);
      chk($sformatf("c5_run_herr_%0d", i), hold_err, 1'b0);
      nxt();
    end
    req = 4'b0000; lock = 4'b0000; #1;
    chk("c5_hold_err", hold_err, 1'b1);
    chk("c5_busy_end", busy, 1'b0);
    nxt();

    // Owner 0 locked, flush together with stall aborts immediately.
    req = 4'b0001; lock = 4'b0001; #1;
    nxt(); req = 4'b0000; #1;
    chk("c6_busy", busy, 1'b1);
    flush = 1'b1; stall = 1'b1; #1;
    chk("c6_flush_gnt", gnt, 4'b0000);
    chk("c6_flush_sel", sel, 2'd0);
    nxt(); flush = 1'b0; stall = 1'b0; lock = 4'b0000; #1;
    chk("c6_busy_end", busy, 1'b0);
    chk("c6_hold_err", hold_err, 1'b0);
    chk("c6_gnt_idle", gnt, 4'b0000);
    nxt();

    // Owner 3 locked, reset pulse abandons ownership.
    req = 4'b1000; lock = 4'b1000; #1;
    nxt(); nxt(); #1;
    chk("c7_busy", busy, 1'b1);
    reset = 1'b0; req = 4'b1111; #1;
    chk("c7_rst_gnt", gnt, 4'b0000);
    chk("c7_rst_sel", sel, 2'd0);
    nxt(); reset = 1'b1; req = 4'b0001; lock = 4'b0000; #1;
    chk("c7_busy_end", busy, 1'b0);
    chk("c7_hold_err", hold_err, 1'b0);
    chk("c7_conflict", conflict, 1'b0);
    chk("c7_gnt", gnt, 4'b0001);
    chk("c7_sel", sel, 2'd0);
    nxt(); req = 4'b0000; #1;
    chk("c7_busy_after", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_owner_arb.md
DEC_OWNER_ARB -- requirements
Module: dec_owner_arb

Interface
REQ-001 Parameter NUM_REQ SHALL be: NUM_REQ, default 4, number of parallel sub-decoders competing for the decode stage.
REQ-002 Parameter MAX_HOLD SHALL be: MAX_HOLD, default 15, maximum unstalled cycles one owner may keep a lock before forced release.
REQ-003 Port clk SHALL be: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be: reset, input, 1, synchronous active-low reset; reset==0 at a rising edge resets all state.
REQ-005 Port req SHALL be: req, input, NUM_REQ, sub-decoder i claims the current instruction.
REQ-006 Port lock SHALL be: lock, input, NUM_REQ, sub-decoder i requests to keep ownership next cycle (multi-phase op).
REQ-007 Port stall SHALL be: stall, input, 1, pipeline stall; freezes arbiter state.
REQ-008 Port flush SHALL be: flush, input, 1, branch/trap flush; aborts any sequence.
REQ-009 Port gnt SHALL be: gnt, output, NUM_REQ, one-hot or zero grant to the owning sub-decoder.
REQ-010 Port sel SHALL be: sel, output, $clog2(NUM_REQ), index of the asserted gnt bit; 0 when gnt==0.
REQ-011 Port busy SHALL be: busy, output, 1, registered; 1 while a locked multi-cycle sequence is in progress.
REQ-012 Port hold_err SHALL be: hold_err, output, 1, registered one-cycle pulse on watchdog expiry.
REQ-013 Port conflict SHALL be: conflict, output, 1, registered one-cycle pulse when more than one req bit was set while IDLE.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and OWNED, plus registers owner (index), hold_cnt ($clog2(MAX_HOLD+1) bits).
REQ-015 In IDLE, gnt SHALL combinationally equal the lowest-index set bit of req; 0 if req==0.
REQ-016 In OWNED, gnt SHALL equal onehot(owner) regardless of req.
REQ-017 sel SHALL be combinational from gnt in the same cycle.
REQ-018 IDLE->OWNED SHALL occur when gnt!=0, lock[sel]==1, stall==0, flush==0; owner<=sel, hold_cnt<=0.
REQ-019 IDLE with gnt!=0 and lock[sel]==0 SHALL be a single-cycle grant; state stays IDLE.
REQ-020 In OWNED with stall==0, lock[owner]==1, hold_cnt<MAX_HOLD: stay OWNED, hold_cnt increments by 1.
REQ-021 In OWNED with stall==0, lock[owner]==0: this cycle is the final granted cycle; next state IDLE.
REQ-022 In OWNED with stall==0, lock[owner]==1, hold_cnt==MAX_HOLD: next state IDLE, hold_err<=1 for one cycle; gnt stays asserted in the expiry cycle.
REQ-023 stall==1 and flush==0 SHALL freeze state, owner and hold_cnt; gnt SHALL keep its combinational value; hold_err and conflict SHALL be 0 next cycle.
REQ-024 flush==1 SHALL force gnt=0 and sel=0 in that cycle and next state IDLE, hold_cnt<=0; flush SHALL override stall, lock and watchdog.
REQ-025 conflict SHALL pulse the cycle after an IDLE, unstalled, unflushed cycle with popcount(req)>1.
REQ-026 busy SHALL be 1 exactly while state==OWNED.
REQ-027 Lock bits of non-owners and req bits in OWNED SHALL be ignored.
REQ-028 hold_cnt SHALL never exceed MAX_HOLD; no wrap-around.

Reset
REQ-029 With reset==0 at a clock edge: state<=IDLE, owner<=0, hold_cnt<=0, busy<=0, hold_err<=0, conflict<=0.
REQ-030 While reset==0, gnt SHALL be 0 and sel 0 regardless of inputs.
REQ-031 Reset asserted mid-sequence SHALL abandon ownership; first cycle after release starts in IDLE.

Verification
REQ-032 req=4'b0110, lock=0 for 1 cycle -> gnt=4'b0010, sel=1 same cycle; conflict=1 next cycle; busy stays 0.
REQ-033 req=4'b1000, lock[3]=1 for 3 cycles then 0 -> gnt=4'b1000 for 4 cycles, busy=1 cycles 2-4, IDLE after; req[0] raised mid-sequence never granted.
REQ-034 Owner 2 holds lock with MAX_HOLD=15, no stall -> gnt for 17 cycles (entry + 16 OWNED), hold_err pulse 1 cycle, then IDLE.
REQ-035 Owner 1 locked, stall=1 for 5 cycles mid-sequence -> hold_cnt unchanged, gnt=4'b0010 throughout, no hold_err.
REQ-036 Owner 0 locked, flush=1 together with stall=1 -> gnt=0 that cycle, busy=0 next cycle, state IDLE.
REQ-037 Owner 3 locked, reset=0 for 1 cycle -> gnt=0 during reset, busy=0, hold_err=0 after; req=4'b0001 next cycle grants 4'b0001.
